// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and fills the IF/ID register.
// Optional range/alignment fault checking is enabled with `define FETCH_BOUND_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  output logic              fetch_fault
);

  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        load;

  assign rom_addr    = pc[ROM_AW+1:2];
  assign pc_next_seq = pc + 32'd4;
  assign load        = !if_valid || id_ready;

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_q;
  logic bad_pc;

  // Anything beyond the ROM or not word aligned is a fault, not a silent wrap.
  assign bad_pc      = (|pc[31:ROM_AW+2]) || (|pc[1:0]);
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      fault_q     <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      fault_q  <= 1'b0;
    end else if (load) begin
      if_pc       <= pc;
      if_pc_plus4 <= pc_next_seq;
      if_valid    <= 1'b1;
      if (bad_pc) begin
        // PC stays frozen on the faulting address, so later loads repeat the NOP.
        if_instr <= '0;
        fault_q  <= 1'b1;
      end else begin
        if_instr <= rom_instr;
        pc       <= pc_next_seq;
      end
    end
  end
`else
  assign fetch_fault = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      if_valid <= 1'b0;
    end else if (load) begin
      if_instr    <= rom_instr;
      if_pc       <= pc;
      if_pc_plus4 <= pc_next_seq;
      if_valid    <= 1'b1;
      pc          <= pc_next_seq;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the CPU, directly upstream of the combinational instruction ROM (5-bit word address in, 32-bit instruction out, result valid in the same cycle).
- Owns the program counter and drives the ROM address from it.
- Registers the returned instruction and its PC into the IF/ID pipeline register.
- Handles decode back-pressure (stall) and branch/jump redirects (flush).

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; must be word aligned.
- ROM_AW, 5, ROM word-address width; ROM depth is 2**ROM_AW words.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  ROM_AW  word address to ROM; combinational, equal to pc[ROM_AW+1:2].
- rom_instr  input  32  instruction returned by ROM for rom_addr in the same cycle.
- redirect_valid  input  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  input  32  byte-address target of the redirect.
- id_ready  input  1  decode stage accepts if_instr this cycle.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_instr  output  32  registered instruction.
- if_pc  output  32  byte address of if_instr.
- if_pc_plus4  output  32  if_pc + 4, registered alongside if_pc.
- fetch_fault  output  1  fault flag; functional only with FETCH_BOUND_CHECK_EN, otherwise constant 0.

Behaviour:
- Internal PC register is 32-bit and byte-addressed. The ROM is word-indexed from pc[ROM_AW+1:2]. pc[1:0] is ignored for addressing.
- Reset (synchronous, held across an edge): pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, fetch_fault=0. Reset overrides redirect and stall in the same cycle.
- Define load = !if_valid || id_ready. The IF/ID register may accept a new entry when load is high.
- Priority per cycle, highest first: reset > redirect_valid > load > hold.
- Redirect:
  - pc <= redirect_pc and if_valid <= 0, regardless of id_ready. The fetched instruction is discarded.
  - The target instruction appears at if_valid one cycle after the redirect cycle. Redirect-to-valid latency is 2 edges.
- Load without redirect:
  - if_instr <= rom_instr, if_pc <= pc, if_pc_plus4 <= pc+4, if_valid <= 1, pc <= pc+4.
- Hold (if_valid=1, id_ready=0, no redirect):
  - pc and all IF/ID outputs keep their values. rom_addr is stable.
  - No instruction is lost or duplicated.
- Throughput: one instruction per cycle while id_ready=1. The first valid appears one edge after reset deassertion.
- PC arithmetic is modulo 2**32. pc+4 from 32'hFFFF_FFFC wraps to 0.
- rom_addr wraps modulo 2**ROM_AW when pc exceeds the ROM range. This wrap is silent unless the optional feature is enabled.
- Redirect in the same cycle as id_ready=1 with if_valid=1: decode consumes the current entry, then the register empties (if_valid=0).
- No X may propagate to if_valid under any input sequence after reset.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- Defined:
  - When a load would occur with pc >= 4*(2**ROM_AW) or pc[1:0] != 0, the stage loads if_instr=32'h0000_0000 (NOP), if_pc=pc, if_valid=1 and sets fetch_fault=1.
  - The PC then freezes: no further increments, and subsequent loads repeat the NOP.
  - fetch_fault stays set until reset or redirect_valid. A redirect clears it in the same edge it loads redirect_pc.
- Undefined:
  - No range or alignment checking. The address wraps modulo ROM depth.
  - fetch_fault is tied to 0.

Test Plan:
- ROM model word i = 32'h2400_0000|i; reset 2 cycles, id_ready=1 -> if_valid rises 1 edge after reset drop; if_instr sequence 0x24000000, 0x24000001, 0x24000002; if_pc 0, 4, 8; if_pc_plus4 4, 8, 12.
- Steady fetch, drop id_ready for 3 cycles while if_pc=0x8 -> outputs frozen at 0x24000002/0x8, rom_addr stays 3; after release, next if_pc=0xC with no gap or duplicate.
- redirect_valid with redirect_pc=0x40 while if_pc=0x10 -> next cycle if_valid=0; following cycle if_pc=0x40, if_instr=0x24000010.
- Redirect asserted during a stall (id_ready=0) -> flush still occurs; target 0x20 delivered two edges later with if_instr=0x24000008.
- Reset asserted mid-stream while id_ready=0 -> next edge all outputs 0, pc=RESET_PC; fetch restarts at address 0.
- With FETCH_BOUND_CHECK_EN: redirect to 0x80 (ROM_AW=5) -> fetch_fault=1, if_instr=0, if_pc=0x80 held; redirect to 0x4 -> fault clears, if_instr=0x24000001. Without the macro: same stimulus -> if_instr=0x24000000 (wrap), fetch_fault=0.
